// File: rtl/axis_descriptor_generator.sv
// Descriptor source for the AXIS packet generator: emits {channel, pause, length} words under run-time config.
// Optional feature macro: DESC_GEN_RANDOM_LEN_EN (LFSR-driven random lengths in [min,max]).
module axis_descriptor_generator #(
  parameter int unsigned ID_WIDTH  = 10,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [31:0]            cfg_pkt_count_i,
  input  logic [15:0]            cfg_len_min_i,
  input  logic [15:0]            cfg_len_max_i,
  input  logic [31:0]            cfg_pause_i,
  input  logic [ID_WIDTH-1:0]    cfg_chan_first_i,
  input  logic [ID_WIDTH-1:0]    cfg_chan_last_i,
  output logic [48+ID_WIDTH-1:0] m_desc_data_o,
  output logic                   m_desc_valid_o,
  input  logic                   m_desc_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            sent_count_o,
  output logic [1:0]             state_o
);
  localparam int unsigned DW = 48 + ID_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ISSUE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [31:0]         pkt_count_q, pause_q, sent_q;
  logic [15:0]         len_min_q;
  logic [ID_WIDTH-1:0] chan_first_q, chan_last_q, chan_q, chan_next;
  logic                stop_pend_q, valid_q, done_q;
  logic [DW-1:0]       data_q;
  logic                len_ok;
  logic [15:0]         len_val;
  logic                hs, last_hs;

`ifdef DESC_GEN_RANDOM_LEN_EN
  logic [15:0] len_max_q, range, mask, cand;
  logic [31:0] lfsr_q;

  always_comb begin
    range = (len_max_q > len_min_q) ? (len_max_q - len_min_q) : 16'd0;
    mask  = range | (range >> 1);
    mask  = mask | (mask >> 2);
    mask  = mask | (mask >> 4);
    mask  = mask | (mask >> 8);
    cand  = lfsr_q[15:0] & mask;
    len_ok  = (cand <= range);
    // Accepted candidates never exceed range, so the sum stays within len_max_q.
    len_val = len_min_q + cand;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q    <= LFSR_SEED;
      len_max_q <= '0;
    end else begin
      if (state_q == IDLE && start_i) len_max_q <= cfg_len_max_i;
      if (state_q == LOAD)
        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_len_max_i, LFSR_SEED};
  assign len_ok     = 1'b1;
  assign len_val    = len_min_q;
`endif

  // Handshake: a descriptor transfers on a cycle where m_desc_valid_o && m_desc_ready_i;
  // once valid rises, data and valid stay frozen until that transfer (stop_i does not withdraw it).
  assign hs        = valid_q & m_desc_ready_i;
  assign last_hs   = ((pkt_count_q != 32'd0) && (sent_q + 32'd1 == pkt_count_q))
                     || stop_pend_q || stop_i;
  assign chan_next = ((chan_q == chan_last_q) || (chan_last_q < chan_first_q))
                     ? chan_first_q : chan_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD: begin
        if (stop_i || stop_pend_q) state_d = IDLE;
        else if (len_ok)           state_d = ISSUE;
      end
      ISSUE:   if (hs) state_d = last_hs ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pkt_count_q  <= '0;
      pause_q      <= '0;
      len_min_q    <= '0;
      chan_first_q <= '0;
      chan_last_q  <= '0;
      chan_q       <= '0;
      sent_q       <= '0;
      stop_pend_q  <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
      case (state_q)
        IDLE: if (start_i) begin
          pkt_count_q  <= cfg_pkt_count_i;
          pause_q      <= cfg_pause_i;
          len_min_q    <= (cfg_len_min_i == 16'd0) ? 16'd1 : cfg_len_min_i;
          chan_first_q <= cfg_chan_first_i;
          chan_last_q  <= cfg_chan_last_i;
          chan_q       <= cfg_chan_first_i;
          sent_q       <= '0;
          stop_pend_q  <= 1'b0;
        end
        LOAD: if (state_d == ISSUE) begin
          data_q  <= {chan_q, pause_q, len_val};
          valid_q <= 1'b1;
        end
        ISSUE: begin
          if (stop_i && !hs) stop_pend_q <= 1'b1;
          if (hs) begin
            sent_q  <= sent_q + 32'd1;
            chan_q  <= chan_next;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_desc_data_o  = data_q;
  assign m_desc_valid_o = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign sent_count_o   = sent_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_axis_descriptor_generator.sv
// Directed bench for axis_descriptor_generator: expected descriptors are built from hand-chosen config.
module tb_axis_descriptor_generator;
  localparam int unsigned IDW = 10;
  localparam int unsigned DW  = 48 + IDW;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start_i, stop_i, m_desc_ready_i;
  logic [31:0]    cfg_pkt_count_i, cfg_pause_i;
  logic [15:0]    cfg_len_min_i, cfg_len_max_i;
  logic [IDW-1:0] cfg_chan_first_i, cfg_chan_last_i;
  logic [DW-1:0]  m_desc_data_o;
  logic           m_desc_valid_o, busy_o, done_o;
  logic [31:0]    sent_count_o;
  logic [1:0]     state_o;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  axis_descriptor_generator #(.ID_WIDTH(IDW)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i),
    .cfg_pkt_count_i(cfg_pkt_count_i), .cfg_len_min_i(cfg_len_min_i),
    .cfg_len_max_i(cfg_len_max_i), .cfg_pause_i(cfg_pause_i),
    .cfg_chan_first_i(cfg_chan_first_i), .cfg_chan_last_i(cfg_chan_last_i),
    .m_desc_data_o(m_desc_data_o), .m_desc_valid_o(m_desc_valid_o),
    .m_desc_ready_i(m_desc_ready_i), .busy_o(busy_o), .done_o(done_o),
    .sent_count_o(sent_count_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [IDW-1:0] ch, input logic [31:0] p,
                                       input logic [15:0] l);
    return {ch, p, l};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] cnt, input logic [15:0] mn, input logic [15:0] mx,
                           input logic [31:0] p, input logic [IDW-1:0] cf,
                           input logic [IDW-1:0] cl, input string tag);
    cfg_pkt_count_i = cnt; cfg_len_min_i = mn; cfg_len_max_i = mx;
    cfg_pause_i = p; cfg_chan_first_i = cf; cfg_chan_last_i = cl;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "_lat_busy"}, busy_o, 1);
    check({tag, "_lat_valid"}, m_desc_valid_o, 0);
    // Scramble config to show it was latched at start.
    cfg_pause_i = 32'hDEAD_BEEF; cfg_chan_first_i = 10'd1000; cfg_chan_last_i = 10'd1001;
    cfg_len_min_i = 16'd7; cfg_len_max_i = 16'd9; cfg_pkt_count_i = 32'd1;
  endtask

  // Called at a negedge with ready high: waits for valid, checks it, lets the handshake happen.
  task automatic take_one(input string tag);
    int n;
    logic [DW-1:0] e;
    n = 0;
    while (m_desc_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_valid"}, m_desc_valid_o, 1);
    check({tag, "_data"}, m_desc_data_o, e);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; m_desc_ready_i = 1'b1;
    cfg_pkt_count_i = '0; cfg_len_min_i = '0; cfg_len_max_i = '0;
    cfg_pause_i = '0; cfg_chan_first_i = '0; cfg_chan_last_i = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", m_desc_valid_o, 0);
    check("rst_data", m_desc_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sent", sent_count_o, 0);
    check("rst_state", state_o, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // stop_i in IDLE is ignored
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    @(negedge clk);
    check("idle_stop_busy", busy_o, 0);
    check("idle_stop_done", done_o, 0);

    // Test 1: three descriptors, channels rotate 2,3,2
    exp_q.push_back(mk(10'd2, 32'd10, 16'd64));
    exp_q.push_back(mk(10'd3, 32'd10, 16'd64));
    exp_q.push_back(mk(10'd2, 32'd10, 16'd64));
    start_run(32'd3, 16'd64, 16'd64, 32'd10, 10'd2, 10'd3, "t1");
    check("t1_first_valid", m_desc_valid_o, 0);
    @(negedge clk);
    check("t1_valid_2cyc", m_desc_valid_o, 1);
    take_one("t1_d0");
    check("t1_mid_done", done_o, 0);
    take_one("t1_d1");
    take_one("t1_d2");
    check("t1_done", done_o, 1);
    check("t1_sent", sent_count_o, 3);
    check("t1_busy", busy_o, 0);
    @(negedge clk);
    check("t1_done_pulse", done_o, 0);
    check("t1_sent_hold", sent_count_o, 3);
    check("t1_valid_off", m_desc_valid_o, 0);

    // Test 2: backpressure on the first descriptor; start_i while busy ignored
    exp_q.push_back(mk(10'd5, 32'h1234_5678, 16'd20));
    exp_q.push_back(mk(10'd6, 32'h1234_5678, 16'd20));
    exp_q.push_back(mk(10'd7, 32'h1234_5678, 16'd20));
    exp_q.push_back(mk(10'd5, 32'h1234_5678, 16'd20));
    m_desc_ready_i = 1'b0;
    start_run(32'd4, 16'd20, 16'd20, 32'h1234_5678, 10'd5, 10'd7, "t2");
    @(negedge clk);
    start_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", m_desc_valid_o, 1);
      check("t2_hold_data", m_desc_data_o, exp_q[0]);
      @(negedge clk);
      start_i = 1'b0;
    end
    check("t2_sent_stalled", sent_count_o, 0);
    m_desc_ready_i = 1'b1;
    take_one("t2_d0");
    take_one("t2_d1");
    take_one("t2_d2");
    take_one("t2_d3");
    check("t2_done", done_o, 1);
    check("t2_sent", sent_count_o, 4);

    // Test 3: unlimited run, stop while 8th is waiting; chan_last<chan_first pins channel
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(10'd9, 32'd0, 16'd8));
    start_run(32'd0, 16'd8, 16'd8, 32'd0, 10'd9, 10'd4, "t3");
    for (int i = 0; i < 7; i++) take_one("t3_d");
    m_desc_ready_i = 1'b0;
    @(negedge clk);
    check("t3_8th_valid", m_desc_valid_o, 1);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("t3_stop_hold_valid", m_desc_valid_o, 1);
    check("t3_stop_hold_data", m_desc_data_o, exp_q[0]);
    @(negedge clk);
    check("t3_stop_busy", busy_o, 1);
    check("t3_sent7", sent_count_o, 7);
    m_desc_ready_i = 1'b1;
    take_one("t3_d8");
    check("t3_done", done_o, 1);
    check("t3_sent", sent_count_o, 8);
    check("t3_busy", busy_o, 0);

    // Test 5: min=0 -> length 1; max<min -> length fixed at min
    exp_q.push_back(mk(10'd0, 32'd3, 16'd1));
    exp_q.push_back(mk(10'd0, 32'd3, 16'd1));
    start_run(32'd2, 16'd0, 16'd0, 32'd3, 10'd0, 10'd0, "t5a");
    take_one("t5a_d0");
    take_one("t5a_d1");
    check("t5a_done", done_o, 1);
    exp_q.push_back(mk(10'd1, 32'd4, 16'd100));
    exp_q.push_back(mk(10'd2, 32'd4, 16'd100));
    start_run(32'd2, 16'd100, 16'd50, 32'd4, 10'd1, 10'd2, "t5b");
    take_one("t5b_d0");
    take_one("t5b_d1");
    check("t5b_done", done_o, 1);

    // Test 6: async reset while a descriptor is pending
    exp_q.push_back(mk(10'd0, 32'd7, 16'd30));
    exp_q.push_back(mk(10'd1, 32'd7, 16'd30));
    start_run(32'd0, 16'd30, 16'd30, 32'd7, 10'd0, 10'd1, "t6");
    take_one("t6_d0");
    take_one("t6_d1");
    m_desc_ready_i = 1'b0;
    @(negedge clk);
    check("t6_pre_valid", m_desc_valid_o, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", m_desc_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_sent", sent_count_o, 0);
    check("t6_rst_data", m_desc_data_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_desc_ready_i = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(10'd0, 32'd7, 16'd30));
    exp_q.push_back(mk(10'd1, 32'd7, 16'd30));
    start_run(32'd2, 16'd30, 16'd30, 32'd7, 10'd0, 10'd1, "t6r");
    check("t6r_sent0", sent_count_o, 0);
    take_one("t6r_d0");
    check("t6r_sent1", sent_count_o, 1);
    take_one("t6r_d1");
    check("t6r_sent", sent_count_o, 2);
    check("t6r_done", done_o, 1);

`ifdef DESC_GEN_RANDOM_LEN_EN
    // Test 4: random lengths stay inside [5,300] and reach both ends
    begin
      int hit_min, hit_max, bad, n;
      logic [15:0] l;
      hit_min = 0; hit_max = 0; bad = 0;
      start_run(32'd1000, 16'd5, 16'd300, 32'd0, 10'd0, 10'd3, "t4");
      for (int i = 0; i < 1000; i++) begin
        n = 0;
        while (m_desc_valid_o !== 1'b1 && n < 60) begin
          @(negedge clk);
          n++;
        end
        if (m_desc_valid_o !== 1'b1) begin
          check("t4_timeout", m_desc_valid_o, 1);
          break;
        end
        l = m_desc_data_o[15:0];
        if (l < 16'd5 || l > 16'd300) bad++;
        if (l == 16'd5) hit_min++;
        if (l == 16'd300) hit_max++;
        @(negedge clk);
      end
      check("t4_range_bad", bad, 0);
      check("t4_hit_min", (hit_min > 0), 1);
      check("t4_hit_max", (hit_max > 0), 1);
      check("t4_sent", sent_count_o, 1000);
    end
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
